// File: rtl/serial_shift_pkg.sv
// serial_shift_pkg: state and direction constants shared by the serial shift writer
package serial_shift_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/bit_down_counter.sv
// bit_down_counter: loadable down counter with terminal flag at count==1
// Ports: clk, rst (sync, active-high), load/load_val, en, cnt, last (cnt==1)
module bit_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);
    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    assign last = cnt == W'(1);
endmodule

// File: rtl/serial_shift_writer.sv
// serial_shift_writer: parallel-in, serial-out feeder for a universal shift register
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_dir word handshake;
// sl/il, sr/ir strobe and serial bit pairs; busy, done (one-cycle pulse after last strobe).
// Macro SERIAL_PAUSE_EN adds input pause, which stalls the transfer while in SHIFT.
module serial_shift_writer
    import serial_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SERIAL_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic             sl,
    output logic             il,
    output logic             sr,
    output logic             ir,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             dir_q;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             hold;
    logic             accept;
    logic             step;
    logic             shifting;
`ifdef SERIAL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    // in_ready is gated by rst, so a word offered during reset is never taken
    assign accept   = in_valid && in_ready;
    assign step     = state == ST_SHIFT && !hold;
    assign shifting = !rst && state == ST_SHIFT;
    bit_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CW'(WIDTH)),
        .en       (step),
        .cnt      (cnt),
        .last     (last)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            dir_q <= DIR_LEFT;
        end else if (accept) begin
            state <= ST_SHIFT;
            shreg <= in_data;
            dir_q <= in_dir;
        end else if (step) begin
            shreg <= dir_q == DIR_RIGHT ? shreg >> 1 : shreg << 1;
            state <= last ? ST_DONE : ST_SHIFT;
        end else if (state != ST_SHIFT && state != ST_IDLE)
            state <= ST_IDLE;
    // serial bits stay valid through a pause; only the strobes drop
    assign sl       = shifting && dir_q == DIR_LEFT && !hold;
    assign il       = shifting && dir_q == DIR_LEFT && shreg[WIDTH-1];
    assign sr       = shifting && dir_q == DIR_RIGHT && !hold;
    assign ir       = shifting && dir_q == DIR_RIGHT && shreg[0];
    assign busy     = !rst && (state == ST_SHIFT || state == ST_DONE);
    assign done     = !rst && state == ST_DONE;
    assign in_ready = !rst && state == ST_IDLE;
endmodule
